demux_router_1xn: RTL and testbench
===================================

Name: demux_router_1xn

Overview:
- Registered 1-to-N demultiplexer: the inverse of the 2x1 selector family. One producer stream is steered to one of N consumer channels, or to all of them at once (broadcast).
- Each output channel has a 1-entry holding register with a valid/ready handshake, so back-pressure from one consumer stalls only words addressed to it.
- Sits between the datapath result bus and the per-unit consumer ports (register file, memory write port, I/O).

Parameters:
- DATA_WIDTH, 32, width of one data word.
- SEL_WIDTH, 2, width of the channel select.
- N_OUT, 4, number of output channels; must satisfy 1 <= N_OUT <= 2**SEL_WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  DATA_WIDTH  word to route.
- IN_SEL  input  SEL_WIDTH  destination channel index.
- IN_BCAST  input  1  1 = write the word to all N_OUT channels; IN_SEL is ignored.
- IN_VALID  input  1  producer offers a word.
- IN_READY  output  1  block accepts the word this cycle.
- OUT_DATA  output  N_OUT*DATA_WIDTH  flattened; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- OUT_VALID  output  N_OUT  channel i holds a word.
- OUT_READY  input  N_OUT  consumer i takes the word.
- BUSY  output  1  OR of all OUT_VALID bits.
- ERR  output  1  sticky: a word was addressed to a nonexistent channel.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - OUT_VALID = 0, OUT_DATA = 0, ERR = 0, BUSY = 0.
  - Held words are discarded.
  - IN_READY follows its combinational rule from the reset state and therefore reads 1 during reset, but no word is accepted while RST = 1.
- Per channel i: can_accept[i] = ~OUT_VALID[i] | OUT_READY[i]. A slot that is draining this cycle can be refilled in the same cycle.
- IN_READY, combinational:
  - IN_BCAST = 1: AND of can_accept over all N_OUT channels.
  - IN_BCAST = 0 and IN_SEL < N_OUT: can_accept[IN_SEL].
  - IN_BCAST = 0 and IN_SEL >= N_OUT: 1 (the word is sunk).
- IN_READY has a combinational path from OUT_READY, IN_SEL and IN_BCAST. It must not depend on IN_VALID.
- accept = IN_VALID & IN_READY & ~RST.
- On accept with a valid target (channel IN_SEL, or all channels if broadcast): next edge OUT_DATA[t] <= IN_DATA and OUT_VALID[t] <= 1.
  - Latency: 1 cycle from the accept edge to OUT_VALID.
  - Throughput: 1 word/cycle per channel when its consumer holds OUT_READY = 1.
- On accept with IN_SEL >= N_OUT (only possible when N_OUT < 2**SEL_WIDTH): the word is dropped, no channel changes, and ERR <= 1. ERR is cleared only by reset.
- Channel not loaded this cycle with OUT_VALID & OUT_READY: OUT_VALID <= 0; OUT_DATA keeps its last value.
- Simultaneous drain and load on the same channel: the load wins, OUT_VALID stays 1, and the new data is presented.
- While OUT_VALID[i] & ~OUT_READY[i], OUT_DATA[i] is stable; no overwrite is allowed.
- OUT_READY[i] while OUT_VALID[i] = 0 has no effect.
- Broadcast loads every channel on the same edge; partial broadcast never occurs.
- BUSY = |OUT_VALID (combinational from registers).
- No internal FSM beyond the per-channel valid bit; each slot has 2 states: EMPTY and FULL.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on hold, or on drain with load.

Decomposition:
- Shared project definitions header supplies the default data width (32) and the select/channel-count defaults used by this block and the selector family.
- One natural sub-module: demux_chan_slot. It is a single holding register plus valid bit with the ports CLK, RST, load, data_in, out_ready, out_valid, out_data, can_accept. The top instantiates N_OUT of these in a generate loop and adds the select decode, IN_READY logic and ERR flag.

Test Plan:
- Reset: assert RST for 2 cycles with IN_VALID = 1 -> OUT_VALID = 4'b0000, OUT_DATA = 0, ERR = 0, no load occurs; after release, send 0xDEADBEEF to IN_SEL = 2 -> OUT_VALID = 4'b0100 one cycle later and channel 2 data = 0xDEADBEEF.
- Back-pressure: fill channel 1 with 0x11 while OUT_READY[1] = 0, then offer 0x22 to channel 1 -> IN_READY = 0 and channel 1 holds 0x11; offer 0x33 to channel 3 -> IN_READY = 1 and channel 3 = 0x33 next cycle.
- Same-cycle drain and refill: channel 0 full with 0xA0, OUT_READY[0] = 1 and IN_SEL = 0 carrying 0xA1 -> IN_READY = 1, OUT_VALID[0] stays 1, data becomes 0xA1. Streaming 0..15 yields 16 words in order with no bubbles.
- Broadcast: channel 2 full and stalled, IN_BCAST = 1 with 0x55AA55AA -> IN_READY = 0 and nothing loads; release OUT_READY[2] -> all four channels load 0x55AA55AA on the same edge, OUT_VALID = 4'b1111.
- Invalid select (N_OUT = 3): IN_SEL = 3 with 0x77 -> IN_READY = 1, no OUT_VALID change, ERR = 1 and it stays 1 until RST.
- Reset mid-operation: channels 0 and 3 full and stalled, pulse RST asynchronously between edges -> OUT_VALID = 0 immediately, BUSY = 0, and words are not re-presented after release.

Source files
------------

// File: rtl/demux_router_1xn_pkg.sv
// Shared definitions for the demux router and the selector family:
// default widths/channel counts and the per-slot occupancy encoding.
package demux_router_1xn_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_SEL_WIDTH  = 2;
    localparam int unsigned DEF_N_OUT      = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux_chan_slot.sv
// One output channel: a single holding register plus its occupancy bit,
// with a valid/ready handshake toward the consumer.
import demux_router_1xn_pkg::*;

module demux_chan_slot #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  can_accept
);

    slot_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = data_q;
    // A slot draining this cycle may be refilled on the same edge.
    assign can_accept = ~out_valid | out_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = data_in;
        end else if (out_valid && out_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/demux_router_1xn.sv
// Registered 1-to-N demultiplexer with broadcast. Each channel has its own
// 1-entry slot, so a stalled consumer only blocks words addressed to it.
import demux_router_1xn_pkg::*;

module demux_router_1xn #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH,
    parameter int unsigned N_OUT      = DEF_N_OUT
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_WIDTH-1:0]       IN_DATA,
    input  logic [SEL_WIDTH-1:0]        IN_SEL,
    input  logic                        IN_BCAST,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    output logic [N_OUT*DATA_WIDTH-1:0] OUT_DATA,
    output logic [N_OUT-1:0]            OUT_VALID,
    input  logic [N_OUT-1:0]            OUT_READY,
    output logic                        BUSY,
    output logic                        ERR
);

    logic [N_OUT-1:0]                 sel_hit;
    logic [N_OUT-1:0]                 can_accept;
    logic [N_OUT-1:0]                 load;
    logic [N_OUT-1:0][DATA_WIDTH-1:0] slot_data;
    logic                             sel_in_range;
    logic                             accept;
    logic                             err_q, err_d;

    // One-hot decode; an out-of-range select simply hits no channel.
    for (genvar i = 0; i < N_OUT; i++) begin : g_chan
        assign sel_hit[i] = (IN_SEL == SEL_WIDTH'(i));
        assign load[i]    = accept & (IN_BCAST | sel_hit[i]);

        demux_chan_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .CLK        (CLK),
            .RST        (RST),
            .load       (load[i]),
            .data_in    (IN_DATA),
            .out_ready  (OUT_READY[i]),
            .out_valid  (OUT_VALID[i]),
            .out_data   (slot_data[i]),
            .can_accept (can_accept[i])
        );

        assign OUT_DATA[i*DATA_WIDTH +: DATA_WIDTH] = slot_data[i];
    end

    assign sel_in_range = |sel_hit;

    // Independent of IN_VALID; unroutable words are always sunk.
    always_comb begin
        if (IN_BCAST)
            IN_READY = &can_accept;
        else if (sel_in_range)
            IN_READY = |(sel_hit & can_accept);
        else
            IN_READY = 1'b1;
    end

    assign accept = IN_VALID & IN_READY & ~RST;
    assign BUSY   = |OUT_VALID;
    assign ERR    = err_q;

    always_comb begin
        err_d = err_q;
        if (accept && !IN_BCAST && !sel_in_range)
            err_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

endmodule

// File: tb/tb_demux_router_1xn.sv
// Directed bench for demux_router_1xn: a 4-channel instance for the main
// datapath and a 3-channel instance for the unroutable-select error flag.
module tb_demux_router_1xn;

    logic         CLK;
    logic         RST;
    logic [31:0]  in_data;
    logic [1:0]   in_sel;
    logic         in_bcast;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic         busy;
    logic         err;

    logic         in_valid3;
    logic         in_ready3;
    logic [95:0]  out_data3;
    logic [2:0]   out_valid3;
    logic [2:0]   out_ready3;
    logic         busy3;
    logic         err3;

    int vectors;
    int miscompares;

    demux_router_1xn #(.DATA_WIDTH(32), .SEL_WIDTH(2), .N_OUT(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .IN_DATA(in_data), .IN_SEL(in_sel),
        .IN_BCAST(in_bcast), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .BUSY(busy), .ERR(err)
    );

    demux_router_1xn #(.DATA_WIDTH(32), .SEL_WIDTH(2), .N_OUT(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .IN_DATA(in_data), .IN_SEL(in_sel),
        .IN_BCAST(in_bcast), .IN_VALID(in_valid3), .IN_READY(in_ready3),
        .OUT_DATA(out_data3), .OUT_VALID(out_valid3), .OUT_READY(out_ready3),
        .BUSY(busy3), .ERR(err3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h1234_5678;
        tick(); tick();
        vectors++;
        if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL rst_valid: got %b want 0000", out_valid); end
        vectors++;
        if (out_data !== 128'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", out_data); end
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_err_busy: got err=%b busy=%b want 0 0", err, busy); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        RST = 1'b0; in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 4'b0100) begin miscompares++; $display("FAIL first_valid: got %b want 0100", out_valid); end
        vectors++;
        if (out_data[95:64] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL first_data: got %h want deadbeef", out_data[95:64]); end
        out_ready = 4'hF;
        tick();
        out_ready = 4'h0;
        vectors++;
        if (out_valid !== 4'b0000 || out_data[95:64] !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL drain_keep: got v=%b d=%h want 0000 deadbeef", out_valid, out_data[95:64]);
        end
    endtask

    task automatic test_backpressure();
        in_sel = 2'd1; in_data = 32'h11; in_valid = 1'b1;
        tick();
        in_data = 32'h22;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_blocked: got %b want 0", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 4'b0010 || out_data[63:32] !== 32'h11) begin
            miscompares++; $display("FAIL bp_hold: got v=%b d=%h want 0010 11", out_valid, out_data[63:32]);
        end
        in_sel = 2'd3; in_data = 32'h33;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_other_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 4'b1010 || out_data[127:96] !== 32'h33 || out_data[63:32] !== 32'h11) begin
            miscompares++; $display("FAIL bp_other_load: got v=%b d3=%h d1=%h want 1010 33 11", out_valid, out_data[127:96], out_data[63:32]);
        end
        out_ready = 4'hF;
        tick();
        out_ready = 4'h0;
    endtask

    task automatic test_back_to_back();
        in_sel = 2'd0; in_data = 32'hA0; in_valid = 1'b1;
        tick();
        in_data = 32'hA1; out_ready = 4'b0001;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL refill_ready: got %b want 1", in_ready); end
        tick();
        vectors++;
        if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'hA1) begin
            miscompares++; $display("FAIL refill_data: got v=%b d=%h want 1 a1", out_valid[0], out_data[31:0]);
        end
        for (int k = 0; k < 16; k++) begin
            in_data = 32'(k);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready[%0d]: got %b want 1", k, in_ready); end
            tick();
            vectors++;
            if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'(k)) begin
                miscompares++; $display("FAIL stream_word[%0d]: got v=%b d=%h want 1 %h", k, out_valid[0], out_data[31:0], k);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 4'h0;
        vectors++;
        if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL stream_drain: got %b want 0000", out_valid); end
    endtask

    task automatic test_broadcast();
        in_sel = 2'd2; in_data = 32'h99; in_valid = 1'b1;
        tick();
        in_bcast = 1'b1; in_data = 32'h55AA_55AA;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bcast_blocked: got %b want 0", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 4'b0100 || out_data[95:64] !== 32'h99) begin
            miscompares++; $display("FAIL bcast_noload: got v=%b d2=%h want 0100 99", out_valid, out_data[95:64]);
        end
        out_ready = 4'b0100;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bcast_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'h0;
        vectors++;
        if (out_valid !== 4'b1111 || out_data !== {4{32'h55AA_55AA}}) begin
            miscompares++; $display("FAIL bcast_all: got v=%b d=%h want 1111 4x55aa55aa", out_valid, out_data);
        end
        out_ready = 4'hF;
        tick();
        out_ready = 4'h0;
    endtask

    task automatic test_invalid_sel();
        in_sel = 2'd3; in_data = 32'h77; in_valid3 = 1'b1;
        #1;
        vectors++;
        if (in_ready3 !== 1'b1) begin miscompares++; $display("FAIL badsel_ready: got %b want 1", in_ready3); end
        tick();
        in_valid3 = 1'b0;
        vectors++;
        if (out_valid3 !== 3'b000 || err3 !== 1'b1) begin
            miscompares++; $display("FAIL badsel_err: got v=%b err=%b want 000 1", out_valid3, err3);
        end
        in_sel = 2'd1; in_data = 32'h78; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        vectors++;
        if (err3 !== 1'b1 || out_valid3 !== 3'b010 || out_data3[63:32] !== 32'h78) begin
            miscompares++; $display("FAIL badsel_sticky: got err=%b v=%b d1=%h want 1 010 78", err3, out_valid3, out_data3[63:32]);
        end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err4_clean: got %b want 0", err); end
    endtask

    task automatic test_mid_reset();
        in_sel = 2'd0; in_data = 32'hC0; in_valid = 1'b1;
        tick();
        in_sel = 2'd3; in_data = 32'hC3;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 4'b1001 || busy !== 1'b1) begin
            miscompares++; $display("FAIL mid_fill: got v=%b busy=%b want 1001 1", out_valid, busy);
        end
        #3 RST = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 4'b0000 || busy !== 1'b0 || out_data !== 128'h0) begin
            miscompares++; $display("FAIL mid_async: got v=%b busy=%b d=%h want 0000 0 0", out_valid, busy, out_data);
        end
        vectors++;
        if (err3 !== 1'b0 || out_valid3 !== 3'b000) begin
            miscompares++; $display("FAIL mid_err_clear: got err3=%b v3=%b want 0 000", err3, out_valid3);
        end
        #1 RST = 1'b0;
        tick(); tick();
        vectors++;
        if (out_valid !== 4'b0000 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mid_no_replay: got v=%b busy=%b want 0000 0", out_valid, busy);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        RST = 1'b1; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0;
        out_ready = '0; in_valid3 = 1'b0; out_ready3 = '0;
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_broadcast();
        test_invalid_sel();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
